// File: rtl/aes_core_arbiter.sv
// Round-robin arbiter sharing one AES core between N_REQ requesters.
// One transaction in flight; the response is held until the winner takes it.
module aes_core_arbiter #(
  parameter int N_REQ       = 4,
  parameter int DATA_W      = 128,
  parameter int TIMEOUT_CYC = 1024,
  localparam int GW         = $clog2(N_REQ)
) (
  input  logic                    ACLK,
  input  logic                    ARST,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ-1:0]        req_decrypt,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic [N_REQ-1:0]        rsp_valid,
  input  logic [N_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]       rsp_data,
  output logic                    rsp_err,
  output logic                    aes_start,
  output logic                    aes_decrypt,
  output logic [DATA_W-1:0]       aes_data_in,
  input  logic                    aes_valid,
  input  logic [DATA_W-1:0]       aes_data_out,
  output logic                    busy,
  output logic [GW-1:0]           grant_id
);

  localparam int CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_e;

  state_e              state_q, state_d;
  logic [GW-1:0]       grant_q, grant_d;
  logic                dec_q, dec_d;
  logic [DATA_W-1:0]   din_q, din_d;
  logic                start_q, start_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   rdat_q, rdat_d;
  logic                rerr_q, rerr_d;

  logic [GW-1:0]       win;
  logic                found;

  // Scan starts one past the last grant so the previous winner gets lowest priority.
  always_comb begin
    int idx;
    idx   = 0;
    win   = grant_q;
    found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(grant_q) + k) % N_REQ;
      if (!found && req_valid[idx]) begin
        win   = GW'(idx);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    dec_d     = dec_q;
    din_d     = din_q;
    start_d   = start_q;
    cnt_d     = cnt_q;
    rdat_d    = rdat_q;
    rerr_d    = rerr_q;
    req_ready = '0;
    rsp_valid = '0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          req_ready[win] = 1'b1;
          grant_d        = win;
          dec_d          = req_decrypt[win];
          din_d          = req_data[int'(win)*DATA_W +: DATA_W];
          cnt_d          = '0;
          start_d        = 1'b1;
          state_d        = S_BUSY;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q + 1'b1;
        if (aes_valid) begin
          rdat_d  = aes_data_out;
          rerr_d  = 1'b0;
          start_d = 1'b0;
          state_d = S_RESP;
        end else if (TIMEOUT_CYC != 0 && cnt_q == CNT_LAST) begin
          rdat_d  = '0;
          rerr_d  = 1'b1;
          start_d = 1'b0;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid[grant_q] = 1'b1;
        if (rsp_ready[grant_q]) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARST) begin
      state_q <= S_IDLE;
      grant_q <= GW'(N_REQ - 1);
      dec_q   <= 1'b0;
      din_q   <= '0;
      start_q <= 1'b0;
      cnt_q   <= '0;
      rdat_q  <= '0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      dec_q   <= dec_d;
      din_q   <= din_d;
      start_q <= start_d;
      cnt_q   <= cnt_d;
      rdat_q  <= rdat_d;
      rerr_q  <= rerr_d;
    end
  end

  assign rsp_data    = rdat_q;
  assign rsp_err     = rerr_q;
  assign aes_start   = start_q;
  assign aes_decrypt = dec_q;
  assign aes_data_in = din_q;
  assign busy        = (state_q != S_IDLE);
  assign grant_id    = grant_q;

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Randomized bench for aes_core_arbiter against a transaction-level model
// (round-robin pick by modular scan, expected start length = min(delay, timeout)).
module tb_aes_core_arbiter;

  localparam int N  = 4;
  localparam int DW = 128;
  localparam int TO = 16;

  logic            ACLK;
  logic            ARST;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_decrypt;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [N-1:0]    rsp_ready;
  logic [DW-1:0]   rsp_data;
  logic            rsp_err;
  logic            aes_start;
  logic            aes_decrypt;
  logic [DW-1:0]   aes_data_in;
  logic            aes_valid;
  logic [DW-1:0]   aes_data_out;
  logic            busy;
  logic [1:0]      grant_id;

  aes_core_arbiter #(.N_REQ(N), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .ACLK(ACLK), .ARST(ARST),
    .req_valid(req_valid), .req_decrypt(req_decrypt), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .aes_start(aes_start), .aes_decrypt(aes_decrypt), .aes_data_in(aes_data_in),
    .aes_valid(aes_valid), .aes_data_out(aes_data_out),
    .busy(busy), .grant_id(grant_id)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // Core model: answers ~operand after core_delay cycles of start, or never.
  int          core_cnt = 0;
  int          core_delay = 1;
  bit          core_en = 1'b1;
  bit          stray = 1'b0;
  logic [DW-1:0] noise = '0;
  logic        core_hit;

  always @(posedge ACLK) core_cnt <= aes_start ? core_cnt + 1 : 0;
  assign core_hit     = core_en && aes_start && (core_cnt == core_delay - 1);
  assign aes_valid    = core_hit | stray;
  assign aes_data_out = (core_hit && !stray) ? ~aes_data_in : noise;

  int n_chk  = 0;
  int n_fail = 0;
  int last_grant = N - 1;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge ACLK);
    #1;
    noise = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  function automatic int rr_pick(input logic [N-1:0] m, input int last);
    for (int k = 1; k <= N; k++) begin
      if (m[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic txn(input logic [N-1:0] mask, input int delay, input bit en, input int bp,
                     input bit directed);
    logic [DW-1:0] op [N];
    logic [N-1:0]  dec;
    logic [DW-1:0] exp_d;
    logic          exp_e;
    int            w, n, exp_n;
    logic [DW-1:0] d0;
    for (int i = 0; i < N; i++) op[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
    dec = N'($urandom());
    if (directed) begin
      d0 = 128'h00112233445566778899aabbccddeeff;
      for (int i = 0; i < N; i++) op[i] = d0;
      dec = '1;
    end
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = op[i];
    req_valid   = mask;
    req_decrypt = dec;
    core_delay  = delay;
    core_en     = en;
    #1;
    w = rr_pick(mask, last_grant);
    if (w < 0) begin
      chk("req_ready_none", DW'(req_ready), '0);
      return;
    end
    chk("req_ready", DW'(req_ready), DW'(1 << w));
    chk("busy_idle", DW'(busy), '0);
    @(posedge ACLK);
    #1;
    req_valid[w] = 1'b0;
    tick();
    chk("grant_id", DW'(grant_id), DW'(w));
    chk("aes_decrypt", DW'(aes_decrypt), DW'(dec[w]));
    chk("aes_data_in", aes_data_in, op[w]);
    chk("busy_busy", DW'(busy), DW'(1));
    n = 0;
    while (aes_start === 1'b1 && n < 40) begin
      n++;
      if (req_ready !== '0) chk("req_ready_busy", DW'(req_ready), '0);
      tick();
    end
    exp_n = (en && delay <= TO) ? delay : TO;
    chk("start_cycles", DW'(n), DW'(exp_n));
    exp_e = !(en && delay <= TO);
    exp_d = exp_e ? '0 : ~op[w];
    chk("rsp_valid", DW'(rsp_valid), DW'(1 << w));
    chk("rsp_data", rsp_data, exp_d);
    chk("rsp_err", DW'(rsp_err), DW'(exp_e));
    for (int c = 0; c < bp; c++) begin
      rsp_ready = N'($urandom()) & ~(N'(1) << w);
      stray     = 1'($urandom_range(0, 1));
      tick();
      chk("bp_rsp_valid", DW'(rsp_valid), DW'(1 << w));
      chk("bp_rsp_data", rsp_data, exp_d);
      chk("bp_req_ready", DW'(req_ready), '0);
    end
    stray     = 1'b0;
    rsp_ready = N'($urandom()) | (N'(1) << w);
    tick();
    rsp_ready = '0;
    chk("rsp_valid_drop", DW'(rsp_valid), '0);
    chk("busy_after", DW'(busy), '0);
    last_grant = w;
  endtask

  task automatic reset_mid_busy();
    req_valid = 4'b0100;
    req_data  = {4{$urandom(), $urandom(), $urandom(), $urandom()}};
    core_en   = 1'b0;
    #1;
    @(posedge ACLK);
    #1;
    req_valid = '0;
    tick(); tick(); tick();
    chk("start_before_rst", DW'(aes_start), DW'(1));
    ARST = 1'b1;
    tick();
    ARST = 1'b0;
    chk("rst_aes_start", DW'(aes_start), '0);
    chk("rst_rsp_valid", DW'(rsp_valid), '0);
    chk("rst_busy", DW'(busy), '0);
    chk("rst_grant_id", DW'(grant_id), DW'(N - 1));
    last_grant = N - 1;
    tick();
    chk("rst_no_rsp", DW'(rsp_valid), '0);
  endtask

  initial begin
    ARST        = 1'b1;
    req_valid   = '0;
    req_decrypt = '0;
    req_data    = '0;
    rsp_ready   = '0;
    tick(); tick();
    ARST = 1'b0;
    chk("reset_busy", DW'(busy), '0);
    chk("reset_grant_id", DW'(grant_id), DW'(N - 1));
    chk("reset_aes_start", DW'(aes_start), '0);
    chk("reset_aes_decrypt", DW'(aes_decrypt), '0);
    chk("reset_aes_data_in", aes_data_in, '0);
    chk("reset_rsp_valid", DW'(rsp_valid), '0);
    chk("reset_rsp_data", rsp_data, '0);
    chk("reset_rsp_err", DW'(rsp_err), '0);

    for (int c = 0; c < 3; c++) begin
      tick();
      chk("idle_req_ready", DW'(req_ready), '0);
      chk("idle_busy", DW'(busy), '0);
    end

    txn(4'b0100, 5, 1'b1, 0, 1'b1);

    for (int t = 0; t < 6; t++) txn(4'b1111, $urandom_range(1, 8), 1'b1, 0, 1'b0);

    txn(4'b0110, 3, 1'b1, 10, 1'b0);
    txn(4'b0010, 2, 1'b1, 0, 1'b0);

    txn(4'b1000, 1, 1'b0, 2, 1'b0);
    txn(4'b0001, TO, 1'b1, 1, 1'b0);
    txn(4'b0011, TO - 1, 1'b1, 0, 1'b0);
    txn(4'b1100, TO + 1, 1'b1, 0, 1'b0);
    txn(4'b0001, 1, 1'b1, 0, 1'b0);

    reset_mid_busy();
    txn(4'b1111, 4, 1'b1, 0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      txn(N'($urandom_range(1, 15)), $urandom_range(1, 20),
          $urandom_range(0, 5) != 0, $urandom_range(0, 4), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
